data_collector: RTL and testbench
=================================

// Module: data_collector
// PURPOSE
//  Byte-to-word deserializer, the receive-side counterpart of the row data feeder.
//  Accepts DATA_W-bit results streamed from a systolic array edge.
//  Packs LANES consecutive beats into one OUT_W-bit word, first beat in the MSB lane.
//  Holds each packed word in an output register until the consumer takes it.
// PARAMETERS
//  DATA_W  8  width of one input beat (one lane)
//  LANES   7  beats per output word; OUT_W = DATA_W*LANES (localparam, 56 by default)
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       reset, asynchronous, active-high
//  in_valid   in   1       input beat present
//  in_data    in   DATA_W  input beat
//  in_ready   out  1       beat accepted when in_valid && in_ready
//  out_valid  out  1       packed word present
//  out_data   out  OUT_W   packed word
//  out_ready  in   1       word consumed when out_valid && out_ready
//  flush      in   1       (DATA_COLLECTOR_FLUSH_EN only) emit partial word
//  out_bytes  out  $clog2(LANES+1)  (DATA_COLLECTOR_FLUSH_EN only) valid lanes in out_data
// BEHAVIOUR
//  Reset: count=0, asm_reg=0, out_valid=0, out_data=0, out_bytes=0. A partial word in progress is discarded.
//  Beat k of a word (k=0..LANES-1) lands in asm_reg[OUT_W-1-k*DATA_W -: DATA_W], so lane 0 is the MSB.
//  count is 0..LANES-1 and increments per accepted beat.
//  On the beat where count==LANES-1:
//   - the completed word {asm_reg upper lanes, in_data} moves to out_data;
//   - out_valid is set the next cycle and count wraps to 0.
//  Latency: last beat accepted in cycle N -> out_valid=1 in cycle N+1.
//  in_ready = (count != LANES-1) || !out_valid || out_ready.
//   - Combinational path from out_ready to in_ready; no other comb path.
//   - Non-final beats are always accepted, even while the output is stalled.
//  Output stage:
//   - out_data/out_valid are held stable while out_valid && !out_ready.
//   - The same-cycle drain plus new-word load gives back-to-back words, one every LANES beats.
//   - out_valid clears only on a handshake with no new word arriving.
//  An in_data beat that is not accepted has no effect; in_valid may drop at any time.
//  out_bytes reads LANES for every full word.
// CONFIGURATION
//  `DATA_COLLECTOR_FLUSH_EN defined:
//   - flush pulse with count>0 pushes a partial word with unfilled lanes zero, out_bytes=count, count->0.
//   - A beat accepted in the same cycle as flush is included first.
//   - If that beat completes the word, flush is a no-op.
//   - flush with count==0 (after any same-cycle beat) is ignored.
//   - If the output register is occupied and not draining, flush sets a sticky flush_pend.
//   - While flush_pend is set, in_ready=0 and the flush executes on the first cycle the output frees.
//   - Reset clears flush_pend.
//  Macro undefined: no flush port, no out_bytes port, no flush_pend logic.
// STRUCTURE
//  Shared package systolic_pkg holds:
//   - localparams SYS_DATA_W=8 and SYS_LANES=7;
//   - typedef logic [SYS_DATA_W-1:0] lane_t;
//   - typedef logic [SYS_DATA_W*SYS_LANES-1:0] row_word_t.
//  The data feeder and data_collector both use these.
//  Single module, no sub-module: assembly register + lane counter + one-entry output register.
// TESTING
//  1. Reset, then 7 beats 0x11..0x77 with out_ready=1 -> out_data=0x11223344556677, out_valid high 1 cycle, at N+1.
//  2. Loopback: feeder loaded with 0xDEADBEEFCAFE01 and enabled 7 cycles into the collector -> identical word out.
//  3. Hold out_ready=0 and send 14 beats:
//     - word 1 stays stable;
//     - in_ready drops only on beat 14;
//     - raising out_ready lets beat 14 complete word 2 back-to-back.
//  4. Assert reset after 3 beats, then send 7 beats 0xA0..0xA6 -> out_data=0xA0A1A2A3A4A5A6, no stale lanes.
//  5. (FLUSH_EN) 3 beats 0x01,0x02,0x03 then flush -> out_data=0x01020300000000, out_bytes=3.
//     A flush with count==0 produces no word.
//  6. (FLUSH_EN) Flush while a full word is stalled -> in_ready=0 until drain; the partial word follows the next cycle.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and sizes for the systolic array edge: data feeder and data collector.
package systolic_pkg;

    localparam int SYS_DATA_W = 8;
    localparam int SYS_LANES  = 7;

    typedef logic [SYS_DATA_W-1:0]           lane_t;
    typedef logic [SYS_DATA_W*SYS_LANES-1:0] row_word_t;

endpackage

// File: rtl/data_collector.sv
// Deserializer: packs LANES beats (first beat in the MSB lane) into one word held until consumed.
// Optional partial-word flush and out_bytes reporting: define DATA_COLLECTOR_FLUSH_EN.
module data_collector
    import systolic_pkg::*;
#(
    parameter  int DATA_W = SYS_DATA_W,
    parameter  int LANES  = SYS_LANES,
    localparam int OUT_W  = DATA_W * LANES,
    localparam int CNT_W  = $clog2(LANES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_data,
`ifdef DATA_COLLECTOR_FLUSH_EN
    input  logic              flush,
    output logic [CNT_W-1:0]  out_bytes,
`endif
    input  logic              out_ready
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [OUT_W-1:0] asm_q, asm_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] asm_ins_s;
    logic             last_s, drain_s, in_ready_s, accept_s, complete_s;
`ifdef DATA_COLLECTOR_FLUSH_EN
    logic [CNT_W-1:0] out_bytes_q, out_bytes_d;
    logic             flush_pend_q, flush_pend_d;
`endif

    // Handshakes, lane insertion and next-state selection.
    always_comb begin
        last_s  = (count_q == CNT_W'(LANES - 1));
        drain_s = out_valid_q && out_ready;
`ifdef DATA_COLLECTOR_FLUSH_EN
        in_ready_s = !flush_pend_q && (!last_s || !out_valid_q || out_ready);
`else
        in_ready_s = !last_s || !out_valid_q || out_ready;
`endif
        accept_s   = in_valid && in_ready_s;
        complete_s = accept_s && last_s;

        asm_ins_s = asm_q;
        if (accept_s) begin
            asm_ins_s[OUT_W-1-int'(count_q)*DATA_W -: DATA_W] = in_data;
        end else begin
            asm_ins_s = asm_q;
        end

        count_d     = count_q;
        asm_d       = asm_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        // A completing beat reloads the output even while it drains, giving back-to-back words.
        if (complete_s) begin
            count_d     = '0;
            asm_d       = '0;
            out_data_d  = asm_ins_s;
            out_valid_d = 1'b1;
        end else begin
            if (accept_s) begin
                count_d = CNT_W'(count_q + CNT_W'(1));
                asm_d   = asm_ins_s;
            end else begin
                count_d = count_q;
            end
            if (drain_s) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
        end

`ifdef DATA_COLLECTOR_FLUSH_EN
        flush_pend_d = flush_pend_q;
        out_bytes_d  = out_bytes_q;
        if (complete_s) begin
            out_bytes_d = CNT_W'(LANES);
        end else begin
            out_bytes_d = out_bytes_q;
        end
        // Flush sees the word including any same-cycle beat; unfilled lanes are already zero.
        if ((flush || flush_pend_q) && !complete_s && (count_d != '0)) begin
            if (!out_valid_q || out_ready) begin
                out_data_d   = asm_ins_s;
                out_valid_d  = 1'b1;
                out_bytes_d  = count_d;
                count_d      = '0;
                asm_d        = '0;
                flush_pend_d = 1'b0;
            end else begin
                flush_pend_d = 1'b1;
            end
        end else begin
            flush_pend_d = flush_pend_q;
        end
`endif
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= '0;
            asm_q        <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
`ifdef DATA_COLLECTOR_FLUSH_EN
            out_bytes_q  <= '0;
            flush_pend_q <= 1'b0;
`endif
        end else begin
            count_q      <= count_d;
            asm_q        <= asm_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
`ifdef DATA_COLLECTOR_FLUSH_EN
            out_bytes_q  <= out_bytes_d;
            flush_pend_q <= flush_pend_d;
`endif
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
`ifdef DATA_COLLECTOR_FLUSH_EN
    assign out_bytes = out_bytes_q;
`endif

endmodule

// File: tb/tb_data_collector.sv
// Self-checking bench for data_collector: directed scenarios plus randomized traffic against a queue model.
module tb_data_collector;
    import systolic_pkg::*;

    localparam int LANES = SYS_LANES;

    logic      clk = 1'b0;
    logic      reset = 1'b1;
    logic      in_valid = 1'b0;
    lane_t     in_data = '0;
    logic      in_ready;
    logic      out_valid;
    row_word_t out_data;
    logic      out_ready = 1'b0;
    logic      fl_in = 1'b0;
`ifdef DATA_COLLECTOR_FLUSH_EN
    logic [2:0] out_bytes;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model: beats of the word in progress, words waiting at the output, flush pending.
    lane_t     beats[$];
    row_word_t outq[$];
    int        bytesq[$];
    bit        pend = 1'b0;

    data_collector dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
`ifdef DATA_COLLECTOR_FLUSH_EN
        .flush     (fl_in),
        .out_bytes (out_bytes),
`endif
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic row_word_t pack_beats();
        row_word_t w = '0;
        foreach (beats[k]) w = (w << 8) | row_word_t'(beats[k]);
        return w << (8 * (LANES - beats.size()));
    endfunction

    // One clock: drive at negedge, check against the model, then update the model at posedge.
    task automatic step(input bit v, input lane_t d, input bit ordy, input bit fl);
        bit held, acc, drn;
        @(negedge clk);
        in_valid = v; in_data = d; out_ready = ordy; fl_in = fl;
        #1;
        held = (outq.size() != 0);
        chk("out_valid", 64'(out_valid), 64'(held));
        if (held) begin
            chk("out_data", 64'(out_data), 64'(outq[0]));
`ifdef DATA_COLLECTOR_FLUSH_EN
            chk("out_bytes", 64'(out_bytes), 64'(bytesq[0]));
`endif
        end
        chk("in_ready", 64'(in_ready),
            64'(!pend && !((beats.size() == LANES - 1) && held && !ordy)));
        acc = v && in_ready;
        drn = held && ordy;
        @(posedge clk);
        if (drn) begin
            void'(outq.pop_front());
            void'(bytesq.pop_front());
        end
        if (acc) beats.push_back(d);
        if (beats.size() == LANES) begin
            outq.push_back(pack_beats());
            bytesq.push_back(LANES);
            beats.delete();
        end else if ((fl || pend) && beats.size() > 0) begin
            if (outq.size() == 0) begin
                outq.push_back(pack_beats());
                bytesq.push_back(beats.size());
                beats.delete();
                pend = 1'b0;
            end else begin
                pend = 1'b1;
            end
        end
    endtask

    task automatic peek(input string tag, input row_word_t exp);
        #1;
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, 64'(out_data), 64'(exp));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; fl_in = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
`ifdef DATA_COLLECTOR_FLUSH_EN
        chk("rst_bytes", 64'(out_bytes), 64'd0);
`endif
        reset = 1'b0;
        beats.delete(); outq.delete(); bytesq.delete(); pend = 1'b0;
    endtask

    initial begin
        row_word_t wd;
        lane_t b14;

        // 1: basic packing and N+1 latency, one-cycle valid pulse
        do_reset();
        for (int k = 0; k < LANES; k++) step(1'b1, 8'(8'h11 * (k + 1)), 1'b1, 1'b0);
        peek("t1_word", 56'h11223344556677);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        #1 chk("t1_pulse", 64'(out_valid), 64'd0);

        // 2: loopback of a feeder-serialized word, MSB lane first
        wd = 56'hDEADBEEFCAFE01;
        for (int k = 0; k < LANES; k++) step(1'b1, wd[55 - 8 * k -: 8], 1'b1, 1'b0);
        peek("t2_loop", 56'hDEADBEEFCAFE01);

        // 3: stalled output, beat 14 held off until out_ready rises
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 13; k++) step(1'b1, 8'(8'h20 + k), 1'b0, 1'b0);
        peek("t3_word1", 56'h20212223242526);
        b14 = 8'h2D;
        for (int k = 0; k < 3; k++) step(1'b1, b14, 1'b0, 1'b0);
        #1 chk("t3_ready_low", 64'(in_ready), 64'd0);
        chk("t3_stable", 64'(out_data), 64'(56'h20212223242526));
        step(1'b1, b14, 1'b1, 1'b0);
        peek("t3_word2", 56'h2728292A2B2C2D);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // 4: reset mid-word discards partial lanes
        for (int k = 0; k < 3; k++) step(1'b1, 8'hEE, 1'b1, 1'b0);
        do_reset();
        for (int k = 0; k < LANES; k++) step(1'b1, 8'(8'hA0 + k), 1'b1, 1'b0);
        peek("t4_word", 56'hA0A1A2A3A4A5A6);
        step(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef DATA_COLLECTOR_FLUSH_EN
        // 5: partial flush, then a flush with nothing collected
        for (int k = 0; k < 3; k++) step(1'b1, 8'(k + 1), 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        peek("t5_partial", 56'h01020300000000);
        chk("t5_bytes", 64'(out_bytes), 64'd3);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        #1 chk("t5_empty_flush", 64'(out_valid), 64'd0);

        // 6: flush while a full word is stalled becomes pending until drain
        for (int k = 0; k < 9; k++) step(1'b1, 8'(8'h40 + k), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        peek("t6_partial", 56'h47480000000000);
        chk("t6_bytes", 64'(out_bytes), 64'd2);
        step(1'b0, 8'h00, 1'b1, 1'b0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            bit fl = 1'b0;
`ifdef DATA_COLLECTOR_FLUSH_EN
            fl = ($urandom_range(0, 19) == 0);
`endif
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0, fl);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
